// File: rtl/add_reduce.sv
// add_reduce: sequential N-operand unsigned sum using N_ADD shared adders per cycle,
// optionally saturating, with a one-cycle result strobe.
module add_reduce #(
    parameter int N_IN     = 7,
    parameter int WIDTH    = 64,
    parameter int N_ADD    = 2,
    parameter int SATURATE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   r_enable,
    input  logic [N_IN*WIDTH-1:0]  init,
    output logic                   w_enable,
    output logic [WIDTH-1:0]       result,
    output logic                   busy,
    output logic                   overflow
);
    localparam int LW = $clog2(N_IN + 1);

    typedef enum logic [1:0] {IDLE, REDUCE, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ops [N_IN];
    logic [WIDTH-1:0] nxt [N_IN];
    logic [LW-1:0]    l, p, half;
    logic [N_IN-1:0]  cy;

    assign half = l >> 1;
    assign p    = half < LW'(N_ADD) ? half : LW'(N_ADD);

    // lane g holds pair-sum g while g < p, otherwise the surviving operand shifted down by p
    for (genvar g = 0; g < N_IN; g++) begin : g_lane
        logic [WIDTH:0]   s;
        logic [WIDTH-1:0] sh;
        if (2 * g + 1 < N_IN) begin : g_add
            assign s = {1'b0, ops[2*g]} + {1'b0, ops[2*g+1]};
        end else begin : g_none
            assign s = '0;
        end
        always_comb begin
            sh = '0;
            for (int j = 0; j < N_IN; j++)
                if (j == g + int'(p)) sh = ops[j];
        end
        assign nxt[g] = g < int'(p) ? ((SATURATE != 0 && s[WIDTH]) ? {WIDTH{1'b1}} : s[WIDTH-1:0]) : sh;
        assign cy[g]  = g < int'(p) && s[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            l        <= '0;
            w_enable <= 1'b0;
            result   <= '0;
            busy     <= 1'b0;
            overflow <= 1'b0;
            for (int k = 0; k < N_IN; k++) ops[k] <= '0;
        end else if (r_enable) begin
            state    <= REDUCE;
            l        <= LW'(N_IN);
            w_enable <= 1'b0;
            busy     <= 1'b1;
            overflow <= 1'b0;
            for (int k = 0; k < N_IN; k++) ops[k] <= init[k*WIDTH +: WIDTH];
        end else begin
            case (state)
                REDUCE: begin
                    w_enable <= 1'b0;
                    ops      <= nxt;
                    l        <= l - p;
                    overflow <= overflow | (|cy);
                    state    <= (l - p == LW'(1)) ? DONE : REDUCE;
                end
                DONE: begin
                    result   <= ops[0];
                    w_enable <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    w_enable <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_reduce.sv
// tb_add_reduce: directed vectors over several parameter sets plus restart/reset/back-to-back sequences.
module tb_add_reduce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [5:0] re = '0;
    logic [5:0] we, bz, ov;
    logic [7*64-1:0] iv64 = '0;
    logic [7*8-1:0]  iv8 = '0;
    logic [63:0] r0, r1, r2, r3;
    logic [7:0]  r4, r5;
    logic [63:0] rs [6];
    int n = 0;
    int nf = 0;

    always #5 clk = ~clk;

    assign rs[0] = r0;
    assign rs[1] = r1;
    assign rs[2] = r2;
    assign rs[3] = r3;
    assign rs[4] = {56'd0, r4};
    assign rs[5] = {56'd0, r5};

    add_reduce #(.N_IN(7), .WIDTH(64), .N_ADD(2), .SATURATE(0)) d0 (.clk(clk), .rst_n(rst_n), .r_enable(re[0]),
        .init(iv64), .w_enable(we[0]), .result(r0), .busy(bz[0]), .overflow(ov[0]));
    add_reduce #(.N_IN(7), .WIDTH(64), .N_ADD(1), .SATURATE(0)) d1 (.clk(clk), .rst_n(rst_n), .r_enable(re[1]),
        .init(iv64), .w_enable(we[1]), .result(r1), .busy(bz[1]), .overflow(ov[1]));
    add_reduce #(.N_IN(7), .WIDTH(64), .N_ADD(3), .SATURATE(0)) d2 (.clk(clk), .rst_n(rst_n), .r_enable(re[2]),
        .init(iv64), .w_enable(we[2]), .result(r2), .busy(bz[2]), .overflow(ov[2]));
    add_reduce #(.N_IN(2), .WIDTH(64), .N_ADD(1), .SATURATE(0)) d3 (.clk(clk), .rst_n(rst_n), .r_enable(re[3]),
        .init(iv64[127:0]), .w_enable(we[3]), .result(r3), .busy(bz[3]), .overflow(ov[3]));
    add_reduce #(.N_IN(3), .WIDTH(8), .N_ADD(2), .SATURATE(0)) d4 (.clk(clk), .rst_n(rst_n), .r_enable(re[4]),
        .init(iv8[23:0]), .w_enable(we[4]), .result(r4), .busy(bz[4]), .overflow(ov[4]));
    add_reduce #(.N_IN(3), .WIDTH(8), .N_ADD(2), .SATURATE(1)) d5 (.clk(clk), .rst_n(rst_n), .r_enable(re[5]),
        .init(iv8[23:0]), .w_enable(we[5]), .result(r5), .busy(bz[5]), .overflow(ov[5]));

    typedef struct packed {
        int              idx;
        int              lat;
        logic [6:0][63:0] o;
        logic [63:0]     res;
        logic            ovf;
    } vec_t;

    localparam logic [6:0][63:0] SEQ = {64'd7, 64'd6, 64'd5, 64'd4, 64'd3, 64'd2, 64'd1};
    localparam logic [6:0][63:0] TWO = {7{64'd2}};
    localparam logic [6:0][63:0] TEN = {7{64'd10}};
    localparam logic [6:0][63:0] P59 = {64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd9, 64'd5};
    localparam logic [6:0][63:0] BIG = {64'd0, 64'd0, 64'd0, 64'd0, 64'd10, 64'd100, 64'd200};
    localparam logic [6:0][63:0] SML = {64'd0, 64'd0, 64'd0, 64'd0, 64'd3, 64'd2, 64'd1};

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start(input int idx, input logic [6:0][63:0] o);
        for (int k = 0; k < 7; k++) begin
            iv64[k*64 +: 64] = o[k];
            iv8[k*8 +: 8]    = o[k][7:0];
        end
        re[idx] = 1'b1;
        @(posedge clk);
        #1;
        re[idx] = 1'b0;
    endtask

    task automatic watch(input int idx, input int lat, input logic [63:0] er, input logic eo, input string nm);
        for (int c = 1; c <= lat + 1; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s w_enable@E%0d", nm, c), 64'(we[idx]), 64'(c == lat));
            chk($sformatf("%s busy@E%0d", nm, c), 64'(bz[idx]), 64'(c < lat));
            if (c == lat) begin
                chk({nm, " result"}, rs[idx], er);
                chk({nm, " overflow"}, 64'(ov[idx]), 64'(eo));
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 5, SEQ, 64'd28, 1'b0};
        tbl[1] = '{1, 7, SEQ, 64'd28, 1'b0};
        tbl[2] = '{2, 4, SEQ, 64'd28, 1'b0};
        tbl[3] = '{3, 2, P59, 64'd14, 1'b0};
        tbl[4] = '{4, 3, BIG, 64'd54, 1'b1};
        tbl[5] = '{5, 3, BIG, 64'd255, 1'b1};
        tbl[6] = '{4, 3, SML, 64'd6, 1'b0};
        tbl[7] = '{5, 3, SML, 64'd6, 1'b0};
        tbl[8] = '{0, 5, TWO, 64'd14, 1'b0};

        #1;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("reset w_enable d%0d", i), 64'(we[i]), 64'd0);
            chk($sformatf("reset busy d%0d", i), 64'(bz[i]), 64'd0);
            chk($sformatf("reset overflow d%0d", i), 64'(ov[i]), 64'd0);
            chk($sformatf("reset result d%0d", i), rs[i], 64'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            start(tbl[i].idx, tbl[i].o);
            watch(tbl[i].idx, tbl[i].lat, tbl[i].res, tbl[i].ovf, $sformatf("vec%0d", i));
        end

        // restart mid-operation: only the second operation completes
        start(0, SEQ);
        @(posedge clk);
        #1;
        chk("restart early w_enable", 64'(we[0]), 64'd0);
        start(0, TEN);
        watch(0, 5, 64'd70, 1'b0, "restart");

        // restart in the DONE cycle suppresses the pending strobe
        start(0, SEQ);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("done-restart pre w_enable@E%0d", c), 64'(we[0]), 64'd0);
        end
        start(0, TWO);
        chk("done-restart aborted w_enable", 64'(we[0]), 64'd0);
        watch(0, 5, 64'd14, 1'b0, "done-restart");

        // asynchronous reset between edges
        start(0, SEQ);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("async busy", 64'(bz[0]), 64'd0);
        chk("async result", r0, 64'd0);
        chk("async w_enable", 64'(we[0]), 64'd0);
        chk("async overflow", 64'(ov[0]), 64'd0);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post-reset idle w_enable@%0d", c), 64'(we[0]), 64'd0);
        end
        start(0, SEQ);
        watch(0, 5, 64'd28, 1'b0, "post-reset");

        // back-to-back: new strobe during the w_enable cycle
        start(0, SEQ);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        chk("b2b first w_enable", 64'(we[0]), 64'd1);
        chk("b2b first result", r0, 64'd28);
        start(0, TWO);
        watch(0, 5, 64'd14, 1'b0, "b2b second");

        $display("[TB] %0d tests run, %0d failed", n, nf);
        $finish;
    end
endmodule
